alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters: requester 0 is the EX-stage integer path and requester 1 is the address/branch-compare path. It accepts one operation at a time through a valid/ready handshake and registers the operands onto the ALU inputs. It holds them for a programmable number of cycles, then captures the result and the NF/ZF/OF/BF flags into a response register. The response is held until it is consumed.

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the ALU operand/result bus and the
// response port shared by the arbiter (slave) and its environment (master).
interface alu_arbiter_if;
   logic        R0_VALID;
   logic        R0_READY;
   logic [31:0] R0_A;
   logic [31:0] R0_B;
   logic [3:0]  R0_CNRL;
   logic [4:0]  R0_SHAMT;
   logic        R1_VALID;
   logic        R1_READY;
   logic [31:0] R1_A;
   logic [31:0] R1_B;
   logic [3:0]  R1_CNRL;
   logic [4:0]  R1_SHAMT;
   logic [31:0] ALU_A;
   logic [31:0] ALU_B;
   logic [3:0]  ALU_CNRL;
   logic [4:0]  ALU_SHAMT;
   logic [31:0] ALU_OUT;
   logic        NF_OUT;
   logic        ZF_OUT;
   logic        OF_OUT;
   logic        BF_OUT;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic        RSP_ID;
   logic [31:0] RSP_DATA;
   logic [3:0]  RSP_FLAGS;
   logic [15:0] OPS_DONE;

   modport slave (
      input  R0_VALID, R0_A, R0_B, R0_CNRL, R0_SHAMT,
      input  R1_VALID, R1_A, R1_B, R1_CNRL, R1_SHAMT,
      input  ALU_OUT, NF_OUT, ZF_OUT, OF_OUT, BF_OUT, RSP_READY,
      output R0_READY, R1_READY,
      output ALU_A, ALU_B, ALU_CNRL, ALU_SHAMT,
      output RSP_VALID, RSP_ID, RSP_DATA, RSP_FLAGS, OPS_DONE
   );

   modport master (
      output R0_VALID, R0_A, R0_B, R0_CNRL, R0_SHAMT,
      output R1_VALID, R1_A, R1_B, R1_CNRL, R1_SHAMT,
      output ALU_OUT, NF_OUT, ZF_OUT, OF_OUT, BF_OUT, RSP_READY,
      input  R0_READY, R1_READY,
      input  ALU_A, ALU_B, ALU_CNRL, ALU_SHAMT,
      input  RSP_VALID, RSP_ID, RSP_DATA, RSP_FLAGS, OPS_DONE
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between the
// EX-stage path (requester 0) and the address/branch path (requester 1).
// Operands are registered onto the ALU, held EXEC_CYCLES cycles, and the
// result plus flags are captured into a response register held until consumed.
module alu_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic          CLK,
   input  logic          RST,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   state_t      state_q,     state_d;
   logic        last_gnt_q,  last_gnt_d;
   logic        pend_id_q,   pend_id_d;
   logic [3:0]  exec_cnt_q,  exec_cnt_d;
   logic [31:0] alu_a_q,     alu_a_d;
   logic [31:0] alu_b_q,     alu_b_d;
   logic [3:0]  alu_cnrl_q,  alu_cnrl_d;
   logic [4:0]  alu_shamt_q, alu_shamt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q,    rsp_id_d;
   logic [31:0] rsp_data_q,  rsp_data_d;
   logic [3:0]  rsp_flags_q, rsp_flags_d;
   logic [15:0] ops_done_q,  ops_done_d;

   logic        gnt0_s;
   logic        gnt1_s;

   // Grant decode: only in IDLE and never while reset is asserted; a tie goes
   // to the requester that did not win last time.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if ((state_q == ST_IDLE) && !RST) begin
         if (bus.R0_VALID && bus.R1_VALID) begin
            gnt0_s = last_gnt_q;
            gnt1_s = !last_gnt_q;
         end else begin
            gnt0_s = bus.R0_VALID;
            gnt1_s = bus.R1_VALID;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Next-state and datapath: accept in IDLE, count down in EXEC, hold in RESP.
   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      pend_id_d   = pend_id_q;
      exec_cnt_d  = exec_cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_cnrl_d  = alu_cnrl_q;
      alu_shamt_d = alu_shamt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      ops_done_d  = ops_done_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt0_s) begin
               alu_a_d     = bus.R0_A;
               alu_b_d     = bus.R0_B;
               alu_cnrl_d  = bus.R0_CNRL;
               alu_shamt_d = bus.R0_SHAMT;
               last_gnt_d  = 1'b0;
               pend_id_d   = 1'b0;
               exec_cnt_d  = EXEC_LOAD;
               state_d     = ST_EXEC;
            end else if (gnt1_s) begin
               alu_a_d     = bus.R1_A;
               alu_b_d     = bus.R1_B;
               alu_cnrl_d  = bus.R1_CNRL;
               alu_shamt_d = bus.R1_SHAMT;
               last_gnt_d  = 1'b1;
               pend_id_d   = 1'b1;
               exec_cnt_d  = EXEC_LOAD;
               state_d     = ST_EXEC;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (exec_cnt_q != 4'd0) begin
               exec_cnt_d  = exec_cnt_q - 4'd1;
            end else begin
               rsp_data_d  = bus.ALU_OUT;
               rsp_flags_d = {bus.NF_OUT, bus.ZF_OUT, bus.OF_OUT, bus.BF_OUT};
               rsp_id_d    = pend_id_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.RSP_READY) begin
               rsp_valid_d = 1'b0;
               ops_done_d  = ops_done_q + 16'd1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= 1'b1;
         pend_id_q   <= 1'b0;
         exec_cnt_q  <= 4'd0;
         alu_a_q     <= 32'd0;
         alu_b_q     <= 32'd0;
         alu_cnrl_q  <= 4'd0;
         alu_shamt_q <= 5'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_flags_q <= 4'd0;
         ops_done_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         pend_id_q   <= pend_id_d;
         exec_cnt_q  <= exec_cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_cnrl_q  <= alu_cnrl_d;
         alu_shamt_q <= alu_shamt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign bus.R0_READY  = gnt0_s;
   assign bus.R1_READY  = gnt1_s;
   assign bus.ALU_A     = alu_a_q;
   assign bus.ALU_B     = alu_b_q;
   assign bus.ALU_CNRL  = alu_cnrl_q;
   assign bus.ALU_SHAMT = alu_shamt_q;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_ID    = rsp_id_q;
   assign bus.RSP_DATA  = rsp_data_q;
   assign bus.RSP_FLAGS = rsp_flags_q;
   assign bus.OPS_DONE  = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at EXEC_CYCLES=1, one at 4,
// each fed by a small reference ALU.
module tb_alu_arbiter;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   cyc;

   alu_arbiter_if ifa ();
   alu_arbiter_if ifb ();

   alu_arbiter #(.EXEC_CYCLES(1)) u_dut1 (.CLK(clk), .RST(rst), .bus(ifa.slave));
   alu_arbiter #(.EXEC_CYCLES(4)) u_dut4 (.CLK(clk), .RST(rst), .bus(ifb.slave));

   // Reference ALU: add/sub/and/or; anything else is an invalid code (BF=1).
   function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
      logic [31:0] r;
      logic        ov;
      logic        bf;
      r  = 32'd0;
      ov = 1'b0;
      bf = 1'b0;
      case (c)
         4'b0010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         4'b0110: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         default: bf = 1'b1;
      endcase
      return {r, r[31], (r == 32'd0), ov, bf};
   endfunction

   assign {ifa.ALU_OUT, ifa.NF_OUT, ifa.ZF_OUT, ifa.OF_OUT, ifa.BF_OUT} =
      alu_model(ifa.ALU_A, ifa.ALU_B, ifa.ALU_CNRL);
   assign {ifb.ALU_OUT, ifb.NF_OUT, ifb.ZF_OUT, ifb.OF_OUT, ifb.BF_OUT} =
      alu_model(ifb.ALU_A, ifb.ALU_B, ifb.ALU_CNRL);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used to measure handshake spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until instance 1 raises a READY; report which one and when.
   task automatic wait_a_ready(input string tag, output logic g, output int at);
      int n;
      n = 0;
      #1;
      while (!(ifa.R0_READY || ifa.R1_READY) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val(tag, 32'(n < 20), 32'd1);
      g  = ifa.R1_READY;
      at = cyc;
   endtask

   // Wait (bounded) until instance 1 presents a response.
   task automatic wait_a_rsp(input string tag);
      int n;
      n = 0;
      while (!ifa.RSP_VALID && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val(tag, 32'(n < 20), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic g;
      int   at;
      int   last_at;
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      rst   = 1'b1;
      ifa.R0_VALID = 1'b0; ifa.R0_A = 32'd0; ifa.R0_B = 32'd0; ifa.R0_CNRL = 4'd0; ifa.R0_SHAMT = 5'd0;
      ifa.R1_VALID = 1'b0; ifa.R1_A = 32'd0; ifa.R1_B = 32'd0; ifa.R1_CNRL = 4'd0; ifa.R1_SHAMT = 5'd0;
      ifa.RSP_READY = 1'b0;
      ifb.R0_VALID = 1'b0; ifb.R0_A = 32'd0; ifb.R0_B = 32'd0; ifb.R0_CNRL = 4'd0; ifb.R0_SHAMT = 5'd0;
      ifb.R1_VALID = 1'b0; ifb.R1_A = 32'd0; ifb.R1_B = 32'd0; ifb.R1_CNRL = 4'd0; ifb.R1_SHAMT = 5'd0;
      ifb.RSP_READY = 1'b0;

      // ---- reset values ----
      repeat (2) @(posedge clk);
      #1;
      ifa.R0_VALID = 1'b1;
      #1;
      check_val("rst_ready0", 32'(ifa.R0_READY), 32'd0);
      ifa.R0_VALID = 1'b0;
      check_val("rst_rsp_valid", 32'(ifa.RSP_VALID), 32'd0);
      check_val("rst_rsp_id", 32'(ifa.RSP_ID), 32'd0);
      check_val("rst_rsp_data", ifa.RSP_DATA, 32'd0);
      check_val("rst_rsp_flags", 32'(ifa.RSP_FLAGS), 32'd0);
      check_val("rst_ops", 32'(ifa.OPS_DONE), 32'd0);
      check_val("rst_alu_ab", ifa.ALU_A | ifa.ALU_B, 32'd0);
      check_val("rst_alu_cs", 32'({ifa.ALU_CNRL, ifa.ALU_SHAMT}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- single op, EXEC_CYCLES=1: 5+3 ----
      ifa.RSP_READY = 1'b1;
      ifa.R0_A = 32'd5; ifa.R0_B = 32'd3; ifa.R0_CNRL = 4'b0010; ifa.R0_SHAMT = 5'd7;
      ifa.R0_VALID = 1'b1;
      wait_a_ready("t1_ready_to", g, at);
      check_val("t1_gnt", 32'(g), 32'd0);
      @(posedge clk);
      #1;
      ifa.R0_VALID = 1'b0;
      check_val("t1_alu_a", ifa.ALU_A, 32'd5);
      check_val("t1_alu_b", ifa.ALU_B, 32'd3);
      check_val("t1_alu_cs", 32'({ifa.ALU_CNRL, ifa.ALU_SHAMT}), 32'({4'b0010, 5'd7}));
      check_val("t1_rsp_early", 32'(ifa.RSP_VALID), 32'd0);
      @(posedge clk);
      #1;
      check_val("t1_rsp_valid", 32'(ifa.RSP_VALID), 32'd1);
      check_val("t1_rsp_id", 32'(ifa.RSP_ID), 32'd0);
      check_val("t1_rsp_data", ifa.RSP_DATA, 32'd8);
      check_val("t1_rsp_flags", 32'(ifa.RSP_FLAGS), 32'd0);
      @(posedge clk);
      #1;
      check_val("t1_rsp_cleared", 32'(ifa.RSP_VALID), 32'd0);
      check_val("t1_ops", 32'(ifa.OPS_DONE), 32'd1);

      // ---- contention after reset: order 0,1,0,1, 3 cycles apart ----
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ifa.R0_A = 32'd10; ifa.R0_B = 32'd1; ifa.R0_CNRL = 4'b0010;
      ifa.R1_A = 32'd20; ifa.R1_B = 32'd2; ifa.R1_CNRL = 4'b0010;
      ifa.R0_VALID = 1'b1;
      ifa.R1_VALID = 1'b1;
      last_at = 0;
      for (int k = 0; k < 4; k++) begin
         wait_a_ready("cont_ready_to", g, at);
         check_val("cont_gnt", 32'(g), 32'(k % 2));
         if (k > 0) check_val("cont_gap", 32'(at - last_at), 32'd3);
         last_at = at;
         @(posedge clk);
         #1;
         if (k == 3) begin
            ifa.R0_VALID = 1'b0;
            ifa.R1_VALID = 1'b0;
         end
         @(posedge clk);
         #1;
         check_val("cont_rsp_valid", 32'(ifa.RSP_VALID), 32'd1);
         check_val("cont_rsp_id", 32'(ifa.RSP_ID), 32'(k % 2));
         check_val("cont_rsp_data", ifa.RSP_DATA, (k % 2 == 1) ? 32'd22 : 32'd11);
      end
      @(posedge clk);
      #1;
      check_val("cont_ops", 32'(ifa.OPS_DONE), 32'd4);

      // ---- backpressure with R1 waiting, then flags ----
      ifa.RSP_READY = 1'b0;
      ifa.R0_A = 32'd100;        ifa.R0_B = 32'd23; ifa.R0_CNRL = 4'b0010;
      ifa.R1_A = 32'h7FFF_FFFF;  ifa.R1_B = 32'd1;  ifa.R1_CNRL = 4'b0010;
      ifa.R0_VALID = 1'b1;
      ifa.R1_VALID = 1'b1;
      wait_a_ready("bp_ready_to", g, at);
      check_val("bp_gnt", 32'(g), 32'd0);
      @(posedge clk);
      #1;
      ifa.R0_VALID = 1'b0;
      wait_a_rsp("bp_rsp_to");
      for (int i = 0; i < 5; i++) begin
         check_val("bp_hold_data", ifa.RSP_DATA, 32'd123);
         check_val("bp_hold_idflags", 32'({ifa.RSP_VALID, ifa.RSP_ID, ifa.RSP_FLAGS}), 32'({1'b1, 1'b0, 4'b0000}));
         check_val("bp_readys_low", 32'({ifa.R0_READY, ifa.R1_READY}), 32'd0);
         @(posedge clk);
         #1;
      end
      check_val("bp_still_valid", 32'(ifa.RSP_VALID), 32'd1);
      ifa.RSP_READY = 1'b1;
      @(posedge clk);
      #1;
      check_val("bp_consumed", 32'(ifa.RSP_VALID), 32'd0);
      check_val("bp_ops", 32'(ifa.OPS_DONE), 32'd5);
      wait_a_ready("fl_ready_to", g, at);
      check_val("fl_gnt", 32'(g), 32'd1);
      @(posedge clk);
      #1;
      ifa.R1_VALID = 1'b0;
      wait_a_rsp("fl_rsp_to");
      check_val("fl_data", ifa.RSP_DATA, 32'h8000_0000);
      check_val("fl_flags", 32'(ifa.RSP_FLAGS), 32'(4'b1010));
      check_val("fl_id", 32'(ifa.RSP_ID), 32'd1);
      ifa.R1_CNRL = 4'b1111;
      ifa.R1_VALID = 1'b1;
      wait_a_ready("bf_ready_to", g, at);
      check_val("bf_gnt", 32'(g), 32'd1);
      @(posedge clk);
      #1;
      ifa.R1_VALID = 1'b0;
      wait_a_rsp("bf_rsp_to");
      check_val("bf_flag", 32'(ifa.RSP_FLAGS[0]), 32'd1);
      check_val("bf_id", 32'(ifa.RSP_ID), 32'd1);
      @(posedge clk);
      #1;
      check_val("bf_done", 32'({ifa.RSP_VALID, ifa.OPS_DONE}), 32'({1'b0, 16'd7}));

      // ---- reset while in RESP ----
      ifa.RSP_READY = 1'b0;
      ifa.R0_A = 32'd1; ifa.R0_B = 32'd1; ifa.R0_CNRL = 4'b0010;
      ifa.R0_VALID = 1'b1;
      wait_a_ready("rr_ready_to", g, at);
      @(posedge clk);
      #1;
      ifa.R0_VALID = 1'b0;
      wait_a_rsp("rr_rsp_to");
      rst = 1'b1;
      #2;
      check_val("rr_rsp_valid", 32'(ifa.RSP_VALID), 32'd0);
      check_val("rr_ops", 32'(ifa.OPS_DONE), 32'd0);
      check_val("rr_rsp_regs", ifa.RSP_DATA | 32'({ifa.RSP_ID, ifa.RSP_FLAGS}), 32'd0);
      check_val("rr_alu_regs", ifa.ALU_A | ifa.ALU_B | 32'({ifa.ALU_CNRL, ifa.ALU_SHAMT}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ifa.R0_VALID = 1'b1;
      ifa.R1_VALID = 1'b1;
      #1;
      check_val("rr_tie", 32'({ifa.R0_READY, ifa.R1_READY}), 32'(2'b10));
      ifa.R0_VALID = 1'b0;
      ifa.R1_VALID = 1'b0;

      // ---- multicycle hold on the EXEC_CYCLES=4 instance ----
      @(posedge clk);
      #1;
      ifb.RSP_READY = 1'b1;
      ifb.R0_A = 32'h1234_5678; ifb.R0_B = 32'd1; ifb.R0_CNRL = 4'b0010;
      ifb.R0_VALID = 1'b1;
      #1;
      check_val("mc_ready", 32'(ifb.R0_READY), 32'd1);
      @(posedge clk);
      #1;
      ifb.R0_VALID = 1'b0;
      ifb.R0_A = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         check_val("mc_hold_a", ifb.ALU_A, 32'h1234_5678);
         check_val("mc_hold_b", ifb.ALU_B, 32'd1);
         check_val("mc_no_rsp", 32'(ifb.RSP_VALID), 32'd0);
         @(posedge clk);
         #1;
      end
      check_val("mc_rsp_valid", 32'(ifb.RSP_VALID), 32'd1);
      check_val("mc_rsp_data", ifb.RSP_DATA, 32'h1234_5679);
      @(posedge clk);
      #1;
      check_val("mc_ops", 32'(ifb.OPS_DONE), 32'd1);

      // ---- reset while in EXEC on the EXEC_CYCLES=4 instance ----
      ifb.R0_A = 32'd2; ifb.R0_B = 32'd2; ifb.R0_CNRL = 4'b0010;
      ifb.R0_VALID = 1'b1;
      #1;
      check_val("re_ready", 32'(ifb.R0_READY), 32'd1);
      @(posedge clk);
      #1;
      ifb.R0_VALID = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      check_val("re_rsp_valid", 32'(ifb.RSP_VALID), 32'd0);
      check_val("re_ops", 32'(ifb.OPS_DONE), 32'd0);
      check_val("re_rsp_regs", ifb.RSP_DATA | 32'({ifb.RSP_ID, ifb.RSP_FLAGS}), 32'd0);
      check_val("re_alu_regs", ifb.ALU_A | ifb.ALU_B | 32'({ifb.ALU_CNRL, ifb.ALU_SHAMT}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ifb.R0_VALID = 1'b1;
      ifb.R1_VALID = 1'b1;
      #1;
      check_val("re_tie", 32'({ifb.R0_READY, ifb.R1_READY}), 32'(2'b10));
      ifb.R0_VALID = 1'b0;
      ifb.R1_VALID = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_val("re_no_rsp", 32'(ifb.RSP_VALID), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
